// File: rtl/decode_stage_param.sv
// Decode stage: regfile, immediate generator and ID/EX pipeline register.
// Define DECODE_BYPASS_EN for write-through from write-back to the read ports.
module decode_stage_param #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int ALUC_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              ValidD,
  input  logic [2:0]        ImmSrcD,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic [1:0]        ResultSrcD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              WE3,
  input  logic [4:0]        RdW,
  input  logic [XLEN-1:0]   ResultW,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic              ValidE,
  output logic [1:0]        ResultSrcE,
  output logic [ALUC_W-1:0] ALUControlE
);

  localparam int AW = $clog2(NREG);

  typedef struct packed {
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc4;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              reg_write;
    logic              mem_write;
    logic              jump;
    logic              branch;
    logic              alu_src;
    logic              valid;
    logic [1:0]        result_src;
    logic [ALUC_W-1:0] alu_ctl;
  } id_ex_t;

  logic [XLEN-1:0] regs [NREG];
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            wr_en;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic            unused_opcode;
  id_ex_t          d;
  id_ex_t          e;

  assign rs1 = InstrD[19:15];
  assign rs2 = InstrD[24:20];
  assign unused_opcode = &{1'b0, InstrD[6:0]};

  assign wr_en = WE3 && (RdW != 5'd0)
              && (32'(RdW) < NREG);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[RdW[AW-1:0]] <= ResultW;
    end
  end

  function automatic logic [XLEN-1:0]
    rd_port(input logic [4:0] a);
    if (a == 5'd0 || 32'(a) >= NREG)
      return '0;
`ifdef DECODE_BYPASS_EN
    if (WE3 && RdW == a)
      return ResultW;
`endif
    return regs[a[AW-1:0]];
  endfunction

  always_comb begin
    rd1 = rd_port(rs1);
    rd2 = rd_port(rs2);
  end

  always_comb begin
    imm32 = '0;
    unique case (ImmSrcD)
      3'b000: imm32 = {{20{InstrD[31]}},
                       InstrD[31:20]};
      3'b001: imm32 = {{20{InstrD[31]}},
                       InstrD[31:25],
                       InstrD[11:7]};
      3'b010: imm32 = {{20{InstrD[31]}},
                       InstrD[7],
                       InstrD[30:25],
                       InstrD[11:8], 1'b0};
      3'b011: imm32 = {{12{InstrD[31]}},
                       InstrD[19:12],
                       InstrD[20],
                       InstrD[30:21], 1'b0};
      3'b100: imm32 = {InstrD[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end

  // Every format is sign-complete at 32 bits, so widening is a plain sign-extend.
  assign imm = XLEN'($signed(imm32));

  always_comb begin
    d            = '0;
    d.rd1        = rd1;
    d.rd2        = rd2;
    d.pc         = PCD;
    d.pc4        = PCPlus4D;
    d.imm        = imm;
    d.rs1        = rs1;
    d.rs2        = rs2;
    d.rd         = InstrD[11:7];
    d.reg_write  = RegWriteD;
    d.mem_write  = MemWriteD;
    d.jump       = JumpD;
    d.branch     = BranchD;
    d.alu_src    = ALUSrcD;
    d.valid      = ValidD;
    d.result_src = ResultSrcD;
    d.alu_ctl    = ALUControlD;
  end

  always_ff @(posedge clk) begin
    if (rst || FlushE)
      e <= '0;
    else if (!StallE)
      e <= d;
  end

  assign RD1E        = e.rd1;
  assign RD2E        = e.rd2;
  assign PCE         = e.pc;
  assign PCPlus4E    = e.pc4;
  assign ImmExtE     = e.imm;
  assign Rs1E        = e.rs1;
  assign Rs2E        = e.rs2;
  assign RdE         = e.rd;
  assign RegWriteE   = e.reg_write;
  assign MemWriteE   = e.mem_write;
  assign JumpE       = e.jump;
  assign BranchE     = e.branch;
  assign ALUSrcE     = e.alu_src;
  assign ValidE      = e.valid;
  assign ResultSrcE  = e.result_src;
  assign ALUControlE = e.alu_ctl;

endmodule

// File: tb/tb_decode_stage_param.sv
// Scoreboard bench for decode_stage_param (32-bit main instance, 64-bit imm instance).
module tb_decode_stage_param;

`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [10:0] C_ADDI = 11'h460;
  localparam logic [10:0] C_BEQ  = 11'h0A1;
  localparam logic [10:0] C_SW   = 11'h260;
  localparam logic [10:0] C_JAL  = 11'h530;
  localparam logic [10:0] C_LUI  = 11'h47D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, StallE, FlushE, WE3;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic [2:0]  ImmSrcD;
  logic [4:0]  RdW;
  logic [10:0] ctl_d;
  logic        RegWriteD, MemWriteD, JumpD;
  logic        BranchD, ALUSrcD, ValidD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;

  assign {RegWriteD, MemWriteD, JumpD, BranchD,
          ALUSrcD, ValidD, ResultSrcD,
          ALUControlD} = ctl_d;

  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE;
  logic        BranchE, ALUSrcE, ValidE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [10:0] act_ctl;

  assign act_ctl = {RegWriteE, MemWriteE, JumpE,
                    BranchE, ALUSrcE, ValidE,
                    ResultSrcE, ALUControlE};

  decode_stage_param dut (
    .clk(clk), .rst(rst), .InstrD(InstrD),
    .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .ImmSrcD(ImmSrcD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD),
    .StallE(StallE), .FlushE(FlushE),
    .WE3(WE3), .RdW(RdW), .ResultW(ResultW),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ValidE(ValidE),
    .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE)
  );

  logic [63:0] pc64, pc4_64, res64;
  logic [63:0] w_rd1, w_rd2, w_pc, w_pc4, w_imm;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic        w_rw, w_mw, w_j, w_b, w_as, w_v;
  logic [1:0]  w_rs;
  logic [2:0]  w_ac;

  assign pc64   = {32'b0, PCD};
  assign pc4_64 = {32'b0, PCPlus4D};
  assign res64  = {32'b0, ResultW};

  decode_stage_param #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .InstrD(InstrD),
    .PCD(pc64), .PCPlus4D(pc4_64),
    .ValidD(ValidD), .ImmSrcD(ImmSrcD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD),
    .StallE(StallE), .FlushE(FlushE),
    .WE3(WE3), .RdW(RdW), .ResultW(res64),
    .RD1E(w_rd1), .RD2E(w_rd2), .PCE(w_pc),
    .PCPlus4E(w_pc4), .ImmExtE(w_imm),
    .Rs1E(w_rs1), .Rs2E(w_rs2), .RdE(w_rd),
    .RegWriteE(w_rw), .MemWriteE(w_mw),
    .JumpE(w_j), .BranchE(w_b),
    .ALUSrcE(w_as), .ValidE(w_v),
    .ResultSrcE(w_rs), .ALUControlE(w_ac)
  );

  typedef struct {
    string       nm;
    logic [31:0] rd1, rd2, pc, pc4, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [10:0] ctl;
    bit          chk64;
    logic [63:0] imm64;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               nm, act, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    while (q.size() > 0) begin
      x = q.pop_front();
      chk({x.nm, ".rd1"}, 64'(RD1E), 64'(x.rd1));
      chk({x.nm, ".rd2"}, 64'(RD2E), 64'(x.rd2));
      chk({x.nm, ".pc"}, 64'(PCE), 64'(x.pc));
      chk({x.nm, ".pc4"}, 64'(PCPlus4E), 64'(x.pc4));
      chk({x.nm, ".imm"}, 64'(ImmExtE), 64'(x.imm));
      chk({x.nm, ".rs1"}, 64'(Rs1E), 64'(x.rs1));
      chk({x.nm, ".rs2"}, 64'(Rs2E), 64'(x.rs2));
      chk({x.nm, ".rd"}, 64'(RdE), 64'(x.rd));
      chk({x.nm, ".ctl"}, 64'(act_ctl), 64'(x.ctl));
      if (x.chk64)
        chk({x.nm, ".imm64"}, w_imm, x.imm64);
    end
  end

  function automatic exp_t zero(string nm);
    exp_t x;
    x = '{nm: nm, rd1: 0, rd2: 0, pc: 0, pc4: 0,
          imm: 0, rs1: 0, rs2: 0, rd: 0, ctl: 0,
          chk64: 1'b0, imm64: 0};
    return x;
  endfunction

  function automatic exp_t mk(string nm,
    logic [31:0] rd1, logic [31:0] rd2,
    logic [31:0] imm, logic [4:0] rs1,
    logic [4:0] rs2, logic [4:0] rd);
    exp_t x;
    x = zero(nm);
    x.rd1 = rd1; x.rd2 = rd2; x.imm = imm;
    x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
    x.pc = PCD; x.pc4 = PCPlus4D; x.ctl = ctl_d;
    return x;
  endfunction

  task automatic drv(logic [31:0] ins,
    logic [2:0] isrc, logic [10:0] c,
    logic [31:0] pc);
    InstrD = ins; ImmSrcD = isrc; ctl_d = c;
    PCD = pc; PCPlus4D = pc + 32'd4;
  endtask

  task automatic wb(logic we, logic [4:0] rd,
                    logic [31:0] data);
    WE3 = we; RdW = rd; ResultW = data;
  endtask

  task automatic tick(exp_t x);
    q.push_back(x);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin : stim
    exp_t b;
    rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    drv(32'hFFF28313, 3'b000, 11'h7FF, 32'h40);
    wb(1'b1, 5'd5, 32'h55);
    tick(zero("reset"));
    rst = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      drv({7'b0, 5'(2*i+1), 5'(2*i), 3'b0,
           5'(i), 7'h13}, 3'b000,
          11'(i*73), 32'h100 + 32'(4*i));
      tick(mk("rd0", 0, 0, 32'(2*i+1),
              5'(2*i), 5'(2*i+1), 5'(i)));
    end
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    drv(32'h00000013, 3'b000, 11'h0, 32'h200);
    tick(mk("wx5", 0, 0, 0, 0, 0, 0));
    wb(1'b1, 5'd31, 32'hA5A5A5A5);
    drv(32'hFFF28313, 3'b000, C_ADDI, 32'h204);
    tick(mk("addi", 32'hDEADBEEF,
            BYP ? 32'hA5A5A5A5 : 32'h0,
            32'hFFFFFFFF, 5'd5, 5'd31, 5'd6));
    wb(1'b1, 5'd5, 32'h1234);
    drv(32'hFFF28313, 3'b000, C_ADDI, 32'h208);
    tick(mk("byp", BYP ? 32'h1234 : 32'hDEADBEEF,
            32'hA5A5A5A5, 32'hFFFFFFFF,
            5'd5, 5'd31, 5'd6));
    wb(1'b1, 5'd0, 32'hFFFF);
    drv(32'hFFF28313, 3'b000, C_ADDI, 32'h20C);
    tick(mk("after", 32'h1234, 32'hA5A5A5A5,
            32'hFFFFFFFF, 5'd5, 5'd31, 5'd6));
    drv(32'h00000013, 3'b000, C_ADDI, 32'h210);
    tick(mk("x0byp", 0, 0, 0, 0, 0, 0));
    wb(1'b0, 5'd0, 32'h0);
    drv(32'h00000013, 3'b000, C_ADDI, 32'h214);
    tick(mk("x0", 0, 0, 0, 0, 0, 0));
    drv(32'hFFF2AC23, 3'b001, C_SW, 32'h218);
    tick(mk("sw", 32'h1234, 32'hA5A5A5A5,
            32'hFFFFFFF8, 5'd5, 5'd31, 5'd24));
    drv(32'h001000EF, 3'b011, C_JAL, 32'h21C);
    tick(mk("jalp", 0, 0, 32'h800, 0, 5'd1, 5'd1));
    drv(32'hFFDFF06F, 3'b011, C_JAL, 32'h220);
    b = mk("jaln", 32'hA5A5A5A5, 0, 32'hFFFFFFFC,
           5'd31, 5'd29, 5'd0);
    b.chk64 = 1'b1;
    b.imm64 = 64'hFFFFFFFFFFFFFFFC;
    tick(b);
    drv(32'h800000B7, 3'b100, C_LUI, 32'h224);
    b = mk("lui", 0, 0, 32'h80000000, 0, 0, 5'd1);
    b.chk64 = 1'b1;
    b.imm64 = 64'hFFFFFFFF80000000;
    tick(b);
    drv(32'hFFFFFFFF, 3'b101, 11'h7FF, 32'h228);
    tick(mk("isrc5", 32'hA5A5A5A5, 32'hA5A5A5A5,
            0, 5'd31, 5'd31, 5'd31));
    drv(32'hFFFFFFFF, 3'b111, 11'h7FF, 32'h22C);
    tick(mk("isrc7", 32'hA5A5A5A5, 32'hA5A5A5A5,
            0, 5'd31, 5'd31, 5'd31));
    drv(32'hFE000EE3, 3'b010, C_BEQ, 32'h230);
    b = mk("beq", 0, 0, 32'hFFFFFFFC, 0, 0, 5'd29);
    tick(b);
    StallE = 1'b1;
    wb(1'b1, 5'd7, 32'h77);
    drv(32'hFFF28313, 3'b000, C_ADDI, 32'h300);
    b.nm = "stall1";
    tick(b);
    wb(1'b1, 5'd8, 32'h88);
    b.nm = "stall2";
    tick(b);
    FlushE = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    tick(zero("flush_stall"));
    FlushE = 1'b0; StallE = 1'b0;
    drv(32'h00838013, 3'b000, C_ADDI, 32'h304);
    tick(mk("wb_stall", 32'h77, 32'h88, 32'h8,
            5'd7, 5'd8, 5'd0));
    FlushE = 1'b1;
    drv(32'hFFF28313, 3'b000, C_ADDI, 32'h308);
    tick(zero("flush"));
    FlushE = 1'b0;
    rst = 1'b1; StallE = 1'b1;
    wb(1'b1, 5'd9, 32'h99);
    tick(zero("rst_mid"));
    rst = 1'b0; StallE = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    drv(32'h01F28013, 3'b000, C_ADDI, 32'h400);
    tick(mk("cleared", 0, 0, 32'h1F,
            5'd5, 5'd31, 5'd0));
    drv(32'h00048013, 3'b000, C_ADDI, 32'h404);
    tick(mk("cleared9", 0, 0, 0, 5'd9, 5'd0, 5'd0));
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
